mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit that drives the instruction-fetch stage's PC controls (`PC_sel`, `PC_LdEn`, `PC_Immed`) and sequences the decode, execute, memory and write-back datapath controls for each instruction. It consumes `Instr` from the fetch stage and `ALU_zero` from the execute stage. It latches the instruction into an internal IR and steps a Moore state machine once per instruction phase. It sits between the fetch stage and the decode/execute/memory stages as the single source of all datapath enables.

## Interface
Parameters:
- None; opcode map and state encoding are fixed.

Ports:
- `Clk`  in  1  system clock; all state changes on rising edge
- `Reset`  in  1  synchronous, active-high; forces FETCH and clears IR
- `Instr`  in  32  instruction word from the fetch stage (addressed by current PC)
- `ALU_zero`  in  1  ALU result-equals-zero flag
- `IR_LdEn`  out  1  internal IR load strobe (exported for the decode stage)
- `PC_Immed`  out  32  branch offset: sign_ext(IR[15:0]) << 2
- `PC_sel`  out  1  0: PC+4, 1: PC+4+PC_Immed
- `PC_LdEn`  out  1  PC load enable
- `RF_WrEn`  out  1  register-file write enable
- `RF_WrData_sel`  out  1  0: ALU result, 1: memory data
- `RF_B_sel`  out  1  0: read rt (IR[15:11]), 1: read rd (IR[20:16])
- `ALU_Bin_sel`  out  1  0: register B, 1: immediate
- `ALU_func`  out  4  ALU op: 0000 add, 0001 sub, 0010 and, 0011 or, others from R-type func
- `Imm_sel`  out  2  00 sign-extend, 01 zero-fill, 10 shift-left-16
- `MEM_WrEn`  out  1  data-memory write enable
- `ByteOp`  out  1  1 for lb/sb
- `Illegal`  out  1  unknown opcode trapped (see Configuration)

## Operation
- Opcode is IR[31:26]: 100000 R-type; 111000 li; 111001 lui; 110000 addi; 110010 andi; 110011 ori; 111111 b; 010000 beq; 010001 bne; 000011 lb; 000111 sb; 001111 lw; 011111 sw.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- FETCH: IR_LdEn=1, IR <= Instr; next DECODE.
- DECODE: RF_B_sel=1 for sb/sw/beq/bne, otherwise 0. Next: R-type → EXEC_R; li/lui/addi/andi/ori → EXEC_I; lb/lw/sb/sw → MEM_ADDR; b/beq/bne → BRANCH; other → TRAP or FETCH.
- EXEC_R: ALU_Bin_sel=0, ALU_func=IR[3:0]; next WB_ALU.
- EXEC_I: ALU_Bin_sel=1, ALU_func add (li/lui/addi), and (andi), or (ori); Imm_sel 00 (li/addi), 01 (andi/ori), 10 (lui); next WB_ALU.
- MEM_ADDR: ALU add, Imm_sel 00, ALU_Bin_sel=1; loads → MEM_RD, stores → MEM_WR.
- MEM_RD: MEM_WrEn=0, ByteOp per opcode; next WB_MEM.
- MEM_WR: MEM_WrEn=1, ByteOp per opcode, PC_LdEn=1; next FETCH.
- WB_ALU / WB_MEM: RF_WrEn=1, RF_WrData_sel 0/1, PC_LdEn=1; next FETCH.
- BRANCH: ALU sub on rs/rd, PC_LdEn=1. PC_sel=1 for b, for beq with ALU_zero=1, and for bne with ALU_zero=0; else 0. Next FETCH.
- ALU/Imm/ByteOp selects hold their values across consecutive states of one instruction. Outputs not listed for a state are 0.
- Outputs are decoded from state register + IR (Moore); PC_Immed is combinational from IR.

## Timing
- Reset value: state FETCH, IR=0, all outputs 0 (PC_Immed=0, IR_LdEn=0 during the Reset cycle, 1 in the first FETCH after release).
- Instruction latency (cycles, FETCH to last state inclusive): b/beq/bne 3; R-type, ALU-immediate, sb/sw 4; lb/lw 5.
- PC_LdEn is high for exactly one cycle per instruction, in its final state; PC changes on that edge.
- Instr is sampled only at the FETCH edge; changes in other states are ignored.
- ALU_zero is sampled only in BRANCH.
- Reset asserted in any state wins over every transition; no write (RF_WrEn, MEM_WrEn, PC_LdEn) is emitted in that cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined: unknown opcode DECODE → TRAP. TRAP holds forever with Illegal=1 and PC_LdEn=0; it is left only by Reset.
- Undefined: unknown opcode DECODE → FETCH with PC_LdEn=1, PC_sel=0 (2-cycle NOP). Illegal is tied 0 and no TRAP state is compiled.

## Test plan
- Reset 2 cycles, then Instr=0x80000000 (R-type add) → IR_LdEn at cycle 1; RF_WrEn and PC_LdEn high together in cycle 4 only; PC_sel=0.
- Instr=0xC0000005 (addi) → cycle 3 ALU_Bin_sel=1, Imm_sel=00, ALU_func=0000; cycle 4 RF_WrEn=1, RF_WrData_sel=0.
- Instr=0x3C000008 (lw) → MEM_WrEn=0 throughout; WB_MEM in cycle 5 with RF_WrData_sel=1, PC_LdEn=1. sb 0x1C000008 → MEM_WrEn=1, ByteOp=1 in cycle 4.
- beq with IR[15:0]=0x0002: ALU_zero=1 → PC_sel=1, PC_Immed=0x00000008 in cycle 3. Repeat with ALU_zero=0 → PC_sel=0. Then IR[15:0]=0xFFFF → PC_Immed=0xFFFFFFFC.
- Reset asserted during MEM_RD of lw → next state FETCH, no RF_WrEn pulse, all outputs 0 during the Reset cycle.
- Opcode 0x2A with macro defined → Illegal=1 from cycle 3 and held, PC_LdEn stays 0. Without macro → PC_LdEn=1 in cycle 2, Illegal=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: latches the fetched instruction and steps a Moore FSM that drives every datapath enable.
// Build option: CTRL_ILLEGAL_TRAP_EN traps unknown opcodes in TRAP; undefined, they retire as a 2-cycle NOP.
module mc_control_fsm (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Instr,
   input  logic        ALU_zero,
   output logic        IR_LdEn,
   output logic [31:0] PC_Immed,
   output logic        PC_sel,
   output logic        PC_LdEn,
   output logic        RF_WrEn,
   output logic        RF_WrData_sel,
   output logic        RF_B_sel,
   output logic        ALU_Bin_sel,
   output logic [3:0]  ALU_func,
   output logic [1:0]  Imm_sel,
   output logic        MEM_WrEn,
   output logic        ByteOp,
   output logic        Illegal
);

   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_LI    = 6'b111000;
   localparam logic [5:0] OP_LUI   = 6'b111001;
   localparam logic [5:0] OP_ADDI  = 6'b110000;
   localparam logic [5:0] OP_ANDI  = 6'b110010;
   localparam logic [5:0] OP_ORI   = 6'b110011;
   localparam logic [5:0] OP_B     = 6'b111111;
   localparam logic [5:0] OP_BEQ   = 6'b010000;
   localparam logic [5:0] OP_BNE   = 6'b010001;
   localparam logic [5:0] OP_LB    = 6'b000011;
   localparam logic [5:0] OP_SB    = 6'b000111;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SW    = 6'b011111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_BRANCH   = 4'd9,
      S_TRAP     = 4'd10
`else
      S_BRANCH   = 4'd9
`endif
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [31:0] ir_r;
   logic [5:0]  opcode_s;
   logic        is_rtype_s;
   logic        is_alui_s;
   logic        is_load_s;
   logic        is_store_s;
   logic        is_branch_s;
   logic        is_byte_s;
   logic        is_known_s;
   logic [31:0] immed_s;
   logic        unused_ir_s;

   assign opcode_s    = ir_r[31:26];
   assign is_rtype_s  = (opcode_s == OP_RTYPE);
   assign is_alui_s   = (opcode_s == OP_LI) || (opcode_s == OP_LUI) || (opcode_s == OP_ADDI) ||
                        (opcode_s == OP_ANDI) || (opcode_s == OP_ORI);
   assign is_load_s   = (opcode_s == OP_LB) || (opcode_s == OP_LW);
   assign is_store_s  = (opcode_s == OP_SB) || (opcode_s == OP_SW);
   assign is_branch_s = (opcode_s == OP_B) || (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
   assign is_byte_s   = (opcode_s == OP_LB) || (opcode_s == OP_SB);
   assign is_known_s  = is_rtype_s || is_alui_s || is_load_s || is_store_s || is_branch_s;
   assign immed_s     = {{14{ir_r[15]}}, ir_r[15:0], 2'b00};
   // Register-specifier fields are consumed by the decode stage, not here.
   assign unused_ir_s = ^ir_r[25:16];

   // State register and IR; IR only captures Instr on the FETCH edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= S_FETCH;
         ir_r    <= 32'd0;
      end else begin
         state_r <= state_s;
         if (state_r == S_FETCH) begin
            ir_r <= Instr;
         end else begin
            ir_r <= ir_r;
         end
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_FETCH: state_s = S_DECODE;
         S_DECODE: begin
            if (is_rtype_s) begin
               state_s = S_EXEC_R;
            end else if (is_alui_s) begin
               state_s = S_EXEC_I;
            end else if (is_load_s || is_store_s) begin
               state_s = S_MEM_ADDR;
            end else if (is_branch_s) begin
               state_s = S_BRANCH;
            end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_s = S_TRAP;
`else
               state_s = S_FETCH;
`endif
            end
         end
         S_EXEC_R, S_EXEC_I: state_s = S_WB_ALU;
         S_MEM_ADDR: begin
            if (is_load_s) begin
               state_s = S_MEM_RD;
            end else begin
               state_s = S_MEM_WR;
            end
         end
         S_MEM_RD: state_s = S_WB_MEM;
         S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH: state_s = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_TRAP: state_s = S_TRAP;
`endif
         default: state_s = S_FETCH;
      endcase
   end

   // Moore output decode from state and IR; Reset forces every output low.
   always_comb begin
      IR_LdEn       = 1'b0;
      PC_Immed      = 32'd0;
      PC_sel        = 1'b0;
      PC_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      Imm_sel       = 2'b00;
      MEM_WrEn      = 1'b0;
      ByteOp        = 1'b0;
      Illegal       = 1'b0;
      if (Reset) begin
         PC_Immed = 32'd0;
      end else begin
         PC_Immed = immed_s;
         case (state_r)
            S_FETCH: IR_LdEn = 1'b1;
            S_DECODE: begin
               RF_B_sel = is_store_s || (opcode_s == OP_BEQ) || (opcode_s == OP_BNE);
`ifndef CTRL_ILLEGAL_TRAP_EN
               PC_LdEn  = !is_known_s;
`endif
            end
            // ALU selects stay asserted from EXEC through write-back.
            S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
               if (is_rtype_s) begin
                  ALU_func = ir_r[3:0];
               end else begin
                  ALU_Bin_sel = 1'b1;
                  case (opcode_s)
                     OP_ANDI: begin ALU_func = 4'b0010; Imm_sel = 2'b01; end
                     OP_ORI:  begin ALU_func = 4'b0011; Imm_sel = 2'b01; end
                     OP_LUI:  begin ALU_func = 4'b0000; Imm_sel = 2'b10; end
                     default: begin ALU_func = 4'b0000; Imm_sel = 2'b00; end
                  endcase
               end
               RF_WrEn = (state_r == S_WB_ALU);
               PC_LdEn = (state_r == S_WB_ALU);
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM: begin
               ALU_Bin_sel   = 1'b1;
               ByteOp        = is_byte_s && (state_r != S_MEM_ADDR);
               MEM_WrEn      = (state_r == S_MEM_WR);
               RF_WrEn       = (state_r == S_WB_MEM);
               RF_WrData_sel = (state_r == S_WB_MEM);
               PC_LdEn       = (state_r == S_MEM_WR) || (state_r == S_WB_MEM);
            end
            S_BRANCH: begin
               ALU_func = 4'b0001;
               PC_LdEn  = 1'b1;
               PC_sel   = (opcode_s == OP_B) ||
                          ((opcode_s == OP_BEQ) && ALU_zero) ||
                          ((opcode_s == OP_BNE) && !ALU_zero);
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: Illegal = 1'b1;
`endif
            default: IR_LdEn = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: an instruction-level model predicts every output each cycle,
// and literal checks pin the model on the key cycles. Honors CTRL_ILLEGAL_TRAP_EN like the design.
module tb_mc_control_fsm;

   localparam logic [5:0] OP_R = 6'b100000, OP_LI = 6'b111000, OP_LUI = 6'b111001, OP_ADDI = 6'b110000;
   localparam logic [5:0] OP_ANDI = 6'b110010, OP_ORI = 6'b110011, OP_B = 6'b111111, OP_BEQ = 6'b010000;
   localparam logic [5:0] OP_BNE = 6'b010001, OP_LB = 6'b000011, OP_SB = 6'b000111, OP_LW = 6'b001111;
   localparam logic [5:0] OP_SW = 6'b011111;
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct packed {
      logic        ir_ld;
      logic [31:0] pc_immed;
      logic        pc_sel;
      logic        pc_ld;
      logic        rf_wr;
      logic        rf_wd_sel;
      logic        rf_b_sel;
      logic        alu_bin;
      logic [3:0]  alu_func;
      logic [1:0]  imm_sel;
      logic        mem_wr;
      logic        byteop;
      logic        illegal;
   } outs_t;

   logic        Clk, Reset, ALU_zero;
   logic [31:0] Instr;
   logic        IR_LdEn, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
   logic        MEM_WrEn, ByteOp, Illegal;
   logic [31:0] PC_Immed;
   logic [3:0]  ALU_func;
   logic [1:0]  Imm_sel;

   outs_t       act, exp_o;
   outs_t       cap [0:7];
   logic [31:0] prev_ir;
   bit          chk_en;
   int          checks, errors;

   mc_control_fsm dut (
      .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
      .IR_LdEn(IR_LdEn), .PC_Immed(PC_Immed), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn),
      .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
      .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Imm_sel(Imm_sel),
      .MEM_WrEn(MEM_WrEn), .ByteOp(ByteOp), .Illegal(Illegal)
   );

   assign act = {IR_LdEn, PC_Immed, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                 ALU_Bin_sel, ALU_func, Imm_sel, MEM_WrEn, ByteOp, Illegal};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [31:0] immed_of(input logic [31:0] ir);
      logic [31:0] sx;
      sx = {{16{ir[15]}}, ir[15:0]};
      return sx * 32'd4;
   endfunction

   function automatic int lat_of(input logic [31:0] ir);
      case (ir[31:26])
         OP_B, OP_BEQ, OP_BNE: return 3;
         OP_LB, OP_LW: return 5;
         OP_R, OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_SB, OP_SW: return 4;
         default: return 2;
      endcase
   endfunction

   // Expected outputs in cycle k (0 = fetch) of instruction ir.
   function automatic outs_t model(input logic [31:0] ir, input logic [31:0] prev, input int k, input logic az);
      outs_t o;
      logic [5:0] op;
      int lat;
      bit last;
      o = '0;
      op = ir[31:26];
      lat = lat_of(ir);
      last = (k == lat - 1);
      if (k == 0) begin
         o.ir_ld = 1'b1;
         o.pc_immed = immed_of(prev);
         return o;
      end
      o.pc_immed = immed_of(ir);
      if (k == 1) begin
         o.rf_b_sel = (op == OP_SB) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
         o.pc_ld = (lat == 2) && !TRAP_EN;
         return o;
      end
      case (op)
         OP_R: o.alu_func = ir[3:0];
         OP_LI, OP_ADDI: o.alu_bin = 1'b1;
         OP_LUI: begin o.alu_bin = 1'b1; o.imm_sel = 2'b10; end
         OP_ANDI: begin o.alu_bin = 1'b1; o.alu_func = 4'd2; o.imm_sel = 2'b01; end
         OP_ORI: begin o.alu_bin = 1'b1; o.alu_func = 4'd3; o.imm_sel = 2'b01; end
         OP_LB, OP_LW, OP_SB, OP_SW: begin
            o.alu_bin = 1'b1;
            o.byteop = (k >= 3) && ((op == OP_LB) || (op == OP_SB));
            o.mem_wr = last && ((op == OP_SB) || (op == OP_SW));
         end
         OP_B, OP_BEQ, OP_BNE: begin
            o.alu_func = 4'd1;
            o.pc_sel = (op == OP_B) || ((op == OP_BEQ) && az) || ((op == OP_BNE) && !az);
         end
         default: o.illegal = TRAP_EN;
      endcase
      if (last && lat > 2) begin
         o.pc_ld = 1'b1;
         o.rf_wr = !((op == OP_SB) || (op == OP_SW) || (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE));
         o.rf_wd_sel = (op == OP_LB) || (op == OP_LW);
      end
      return o;
   endfunction

   // Per-cycle comparison of all outputs against the model.
   always @(negedge Clk) begin
      if (chk_en) begin
         checks++;
         if (act !== exp_o) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t act=%h req=%h", $time, act, exp_o);
         end
      end
   end

   task automatic pin(input string name, input logic [31:0] a, input logic [31:0] r);
      checks++;
      if (a !== r) begin
         errors++;
         $display("FAIL %s act=%h req=%h", name, a, r);
      end
   endtask

   // Runs one instruction; rst_at >= 0 asserts Reset in that cycle and abandons it.
   task automatic run_instr(input logic [31:0] ir, input logic az, input int rst_at);
      int n;
      n = (rst_at >= 0) ? rst_at + 1 : lat_of(ir);
      for (int k = 0; k < n; k++) begin
         Reset = (k == rst_at);
         Instr = (k == 0) ? ir : $urandom;
         ALU_zero = (k == 2) ? az : 1'($urandom_range(0, 1));
         exp_o = (k == rst_at) ? outs_t'(0) : model(ir, prev_ir, k, az);
         @(negedge Clk);
         cap[k] = act;
         @(posedge Clk);
         #1;
      end
      Reset = 1'b0;
      prev_ir = (rst_at >= 0) ? 32'd0 : ir;
   endtask

   initial begin
      checks = 0; errors = 0; prev_ir = 32'd0;
      Reset = 1'b1; Instr = 32'd0; ALU_zero = 1'b0;
      exp_o = '0; chk_en = 1'b1;
      repeat (2) begin
         @(posedge Clk);
         #1;
      end
      Reset = 1'b0;

      run_instr(32'h80000000, 1'b0, -1);
      pin("radd_irld_c1", {31'd0, cap[0].ir_ld}, 32'd1);
      pin("radd_rfwr_c4", {31'd0, cap[3].rf_wr}, 32'd1);
      pin("radd_pcld_c4", {31'd0, cap[3].pc_ld}, 32'd1);
      pin("radd_pcld_c3", {31'd0, cap[2].pc_ld}, 32'd0);
      pin("radd_pcsel_c4", {31'd0, cap[3].pc_sel}, 32'd0);

      run_instr(32'hC0000005, 1'b0, -1);
      pin("addi_bin_c3", {31'd0, cap[2].alu_bin}, 32'd1);
      pin("addi_imm_c3", {30'd0, cap[2].imm_sel}, 32'd0);
      pin("addi_func_c3", {28'd0, cap[2].alu_func}, 32'd0);
      pin("addi_wdsel_c4", {31'd0, cap[3].rf_wd_sel}, 32'd0);

      run_instr(32'h80000003, 1'b0, -1);
      run_instr(32'hC8000010, 1'b0, -1);
      pin("andi_imm_c3", {30'd0, cap[2].imm_sel}, 32'd1);
      run_instr(32'hCC000010, 1'b0, -1);
      run_instr(32'hE0000007, 1'b0, -1);
      run_instr(32'hE4001234, 1'b0, -1);
      pin("lui_imm_c4", {30'd0, cap[3].imm_sel}, 32'd2);

      run_instr(32'h3C000008, 1'b0, -1);
      pin("lw_memwr_all", {31'd0, cap[0].mem_wr | cap[1].mem_wr | cap[2].mem_wr | cap[3].mem_wr | cap[4].mem_wr}, 32'd0);
      pin("lw_wdsel_c5", {31'd0, cap[4].rf_wd_sel}, 32'd1);
      pin("lw_pcld_c5", {31'd0, cap[4].pc_ld}, 32'd1);

      run_instr(32'h1C000008, 1'b0, -1);
      pin("sb_memwr_c4", {31'd0, cap[3].mem_wr}, 32'd1);
      pin("sb_byteop_c4", {31'd0, cap[3].byteop}, 32'd1);
      run_instr(32'h0C000004, 1'b0, -1);
      run_instr(32'h7C000004, 1'b1, -1);

      run_instr(32'h40000002, 1'b1, -1);
      pin("beq_t_pcsel_c3", {31'd0, cap[2].pc_sel}, 32'd1);
      pin("beq_t_immed_c3", cap[2].pc_immed, 32'h00000008);
      run_instr(32'h40000002, 1'b0, -1);
      pin("beq_nt_pcsel_c3", {31'd0, cap[2].pc_sel}, 32'd0);
      run_instr(32'h4000FFFF, 1'b1, -1);
      pin("beq_neg_immed_c3", cap[2].pc_immed, 32'hFFFFFFFC);
      run_instr(32'h44000003, 1'b0, -1);
      run_instr(32'h44000003, 1'b1, -1);
      run_instr(32'hFC000001, 1'b1, -1);

      run_instr(32'h3C000010, 1'b0, 3);
      pin("lw_rst_rfwr_c4", {31'd0, cap[3].rf_wr}, 32'd0);
      run_instr(32'h80000002, 1'b0, -1);

`ifdef CTRL_ILLEGAL_TRAP_EN
      run_instr(32'hA8000000, 1'b0, 6);
      pin("trap_ill_c3", {31'd0, cap[2].illegal}, 32'd1);
      pin("trap_ill_c6", {31'd0, cap[5].illegal}, 32'd1);
      pin("trap_pcld_c6", {31'd0, cap[5].pc_ld}, 32'd0);
`else
      run_instr(32'hA8000000, 1'b0, -1);
      pin("bad_pcld_c2", {31'd0, cap[1].pc_ld}, 32'd1);
      pin("bad_ill_c2", {31'd0, cap[1].illegal}, 32'd0);
`endif
      run_instr(32'h80000001, 1'b0, -1);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
